cat_wave_sequencer: RTL and testbench

Sequences the cat enemy across a series of attack waves, one clock per frame. It watches the kid position, then runs each wave through arm, warn, rush, hurt and cooldown. It tracks enemy lives, detects escape and kid death, and drives the enable and reset controls of a single cat enemy datapath. It sits between the game-state top level and the enemy module, and feeds blink and status flags to the colour mapper.

---
 rtl/cat_wave_sequencer.sv | 168 ++++++++++++++++
 tb/tb_cat_wave_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cat_wave_sequencer.sv
// cat_wave_sequencer
// Runs the cat enemy through successive attack waves, one step per frame:
// IDLE -> WARN -> ACTIVE <-> HURT -> COOLDOWN -> IDLE ... -> CLEARED,
// with KID_DEAD as the other terminal state.
//
// Ports:
//   frame_clk        frame clock
//   Reset_h          asynchronous active-high reset
//   Kid_position_X/Y kid position, used to arm a wave
//   Enemy_position_X enemy X from the enemy datapath, used for escape
//   hitBullet        bullet overlapped the enemy this frame
//   hitCat           enemy overlapped the kid this frame
//   enemy_reset      one-frame pulse returning the enemy to spawn
//   enemy_visible    enemy is drawn
//   enemy_move       enemy advances this frame
//   warn_blink       blink phase in WARN and HURT
//   enemy_life       remaining lives of the current enemy
//   wave_count       enemies killed so far
//   kid_dead         sticky: kid was hit
//   level_clear      sticky: all waves killed
module cat_wave_sequencer #(
  parameter logic [9:0] TRIGGER_X       = 10'd350,
  parameter logic [9:0] TRIGGER_Y_MAX   = 10'd170,
  parameter int         WARN_FRAMES     = 3,
  parameter int         LIVES           = 3,
  parameter int         INVULN_FRAMES   = 8,
  parameter int         COOLDOWN_FRAMES = 60,
  parameter int         WAVES           = 3,
  parameter logic [9:0] ESCAPE_X        = 10'd2
) (
  input  logic       frame_clk,
  input  logic       Reset_h,
  input  logic [9:0] Kid_position_X,
  input  logic [9:0] Kid_position_Y,
  input  logic [9:0] Enemy_position_X,
  input  logic       hitBullet,
  input  logic       hitCat,
  output logic       enemy_reset,
  output logic       enemy_visible,
  output logic       enemy_move,
  output logic       warn_blink,
  output logic [1:0] enemy_life,
  output logic [2:0] wave_count,
  output logic       kid_dead,
  output logic       level_clear
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WARN     = 3'd1;
  localparam logic [2:0] S_ACTIVE   = 3'd2;
  localparam logic [2:0] S_HURT     = 3'd3;
  localparam logic [2:0] S_COOLDOWN = 3'd4;
  localparam logic [2:0] S_CLEARED  = 3'd5;
  localparam logic [2:0] S_KID_DEAD = 3'd6;

  localparam logic [5:0] WARN_LD   = 6'(WARN_FRAMES - 1);
  localparam logic [5:0] INVULN_LD = 6'(INVULN_FRAMES - 1);
  localparam logic [5:0] COOL_LD   = 6'(COOLDOWN_FRAMES - 1);
  localparam logic [1:0] LIVES_W   = 2'(LIVES);
  localparam logic [2:0] WAVES_W   = 3'(WAVES);

  logic [2:0] state, state_nxt;
  logic [5:0] timer, timer_nxt;
  logic [1:0] life_nxt;
  logic [2:0] wave_nxt;
  logic       armed, escaped;

  assign armed   = (Kid_position_X >= TRIGGER_X) && (Kid_position_Y < TRIGGER_Y_MAX);
  assign escaped = (Enemy_position_X <= ESCAPE_X);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    life_nxt  = enemy_life;
    wave_nxt  = wave_count;
    case (state)
      S_IDLE: begin
        if (armed) begin
          state_nxt = S_WARN;
          timer_nxt = WARN_LD;
        end
      end
      S_WARN: begin
        if (timer == 6'd0) state_nxt = S_ACTIVE;
        else               timer_nxt = timer - 6'd1;
      end
      S_ACTIVE: begin
        if (hitCat) begin
          state_nxt = S_KID_DEAD;
        end else if (hitBullet) begin
          if (enemy_life > 2'd1) begin
            life_nxt  = enemy_life - 2'd1;
            state_nxt = S_HURT;
            timer_nxt = INVULN_LD;
          end else begin
            life_nxt  = 2'd0;
            if (wave_count < WAVES_W) wave_nxt = wave_count + 3'd1;
            state_nxt = S_COOLDOWN;
            timer_nxt = COOL_LD;
          end
        end else if (escaped) begin
          state_nxt = S_COOLDOWN;
          timer_nxt = COOL_LD;
        end
      end
      S_HURT: begin
        // Invulnerable to bullets, but contact and escape still count.
        if (hitCat) begin
          state_nxt = S_KID_DEAD;
        end else if (escaped) begin
          state_nxt = S_COOLDOWN;
          timer_nxt = COOL_LD;
        end else if (timer == 6'd0) begin
          state_nxt = S_ACTIVE;
        end else begin
          timer_nxt = timer - 6'd1;
        end
      end
      S_COOLDOWN: begin
        if (timer == 6'd0) begin
          if (wave_count == WAVES_W) begin
            state_nxt = S_CLEARED;
          end else begin
            life_nxt  = LIVES_W;
            state_nxt = S_IDLE;
          end
        end else begin
          timer_nxt = timer - 6'd1;
        end
      end
      default: ;  // CLEARED / KID_DEAD hold until reset
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge frame_clk or posedge Reset_h) begin
    if (Reset_h) begin
      state         <= S_IDLE;
      timer         <= 6'd0;
      enemy_reset   <= 1'b1;
      enemy_visible <= 1'b0;
      enemy_move    <= 1'b0;
      warn_blink    <= 1'b0;
      enemy_life    <= LIVES_W;
      wave_count    <= 3'd0;
      kid_dead      <= 1'b0;
      level_clear   <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      enemy_life    <= life_nxt;
      wave_count    <= wave_nxt;
      // Pulse only on the entry edge into COOLDOWN.
      enemy_reset   <= (state_nxt == S_COOLDOWN) && (state != S_COOLDOWN);
      enemy_visible <= (state_nxt == S_WARN) || (state_nxt == S_ACTIVE) ||
                       (state_nxt == S_HURT) || (state_nxt == S_KID_DEAD);
      enemy_move    <= (state_nxt == S_ACTIVE) || (state_nxt == S_HURT);
      // Blink starts at 1 on entry and toggles while the state persists.
      if ((state_nxt == S_WARN) || (state_nxt == S_HURT))
        warn_blink  <= (state == state_nxt) ? ~warn_blink : 1'b1;
      else
        warn_blink  <= 1'b0;
      kid_dead      <= kid_dead    | (state_nxt == S_KID_DEAD);
      level_clear   <= level_clear | (state_nxt == S_CLEARED);
    end
  end

endmodule

// File: tb/tb_cat_wave_sequencer.sv
// Directed bench for cat_wave_sequencer. Outputs are packed as
// {enemy_reset, enemy_visible, enemy_move, warn_blink, enemy_life[1:0],
//  wave_count[2:0], kid_dead, level_clear} and compared on the falling edge.
module tb_cat_wave_sequencer;
  logic       frame_clk = 1'b0;
  logic       Reset_h;
  logic [9:0] Kid_position_X, Kid_position_Y, Enemy_position_X;
  logic       hitBullet, hitCat;
  logic       enemy_reset, enemy_visible, enemy_move, warn_blink;
  logic [1:0] enemy_life;
  logic [2:0] wave_count;
  logic       kid_dead, level_clear;
  logic [11:0] obs;
  int checks = 0;
  int failures = 0;

  assign obs = {enemy_reset, enemy_visible, enemy_move, warn_blink, enemy_life,
                wave_count, kid_dead, level_clear};

  cat_wave_sequencer dut (
    .frame_clk(frame_clk), .Reset_h(Reset_h),
    .Kid_position_X(Kid_position_X), .Kid_position_Y(Kid_position_Y),
    .Enemy_position_X(Enemy_position_X), .hitBullet(hitBullet), .hitCat(hitCat),
    .enemy_reset(enemy_reset), .enemy_visible(enemy_visible), .enemy_move(enemy_move),
    .warn_blink(warn_blink), .enemy_life(enemy_life), .wave_count(wave_count),
    .kid_dead(kid_dead), .level_clear(level_clear)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  task automatic do_reset();
    Reset_h = 1'b1;
    @(negedge frame_clk);
    Reset_h = 1'b0;
  endtask

  // From IDLE with the kid in the trigger zone: 1 frame to arm, 3 WARN frames.
  task automatic arm_to_active();
    repeat (4) tick();
  endtask

  // Bullets every frame from ACTIVE: hit, 8 HURT, hit, 8 HURT, fatal hit.
  task automatic kill_wave();
    hitBullet = 1'b1;
    repeat (19) tick();
    hitBullet = 1'b0;
  endtask

  task automatic test_reset();
    Reset_h = 1'b1;
    @(negedge frame_clk);
    checks++;
    if (obs !== 12'b1_0_0_0_11_000_0_0) begin
      failures++; $display("FAIL reset_held obs=%b exp=%b", obs, 12'b1_0_0_0_11_000_0_0);
    end
    Reset_h = 1'b0;
    #1;
    checks++;
    if (obs !== 12'b1_0_0_0_11_000_0_0) begin
      failures++; $display("FAIL reset_released obs=%b exp=%b", obs, 12'b1_0_0_0_11_000_0_0);
    end
    tick();
    checks++;
    if (obs !== 12'b0_0_0_0_11_000_0_0) begin
      failures++; $display("FAIL reset_first_frame obs=%b exp=%b", obs, 12'b0_0_0_0_11_000_0_0);
    end
  endtask

  task automatic test_arm();
    Kid_position_X = 10'd349; Kid_position_Y = 10'd100;
    repeat (5) tick();
    checks++;
    if (obs !== 12'b0_0_0_0_11_000_0_0) begin
      failures++; $display("FAIL arm_x349 obs=%b exp=%b", obs, 12'b0_0_0_0_11_000_0_0);
    end
    Kid_position_X = 10'd400; Kid_position_Y = 10'd170;
    tick();
    checks++;
    if (obs !== 12'b0_0_0_0_11_000_0_0) begin
      failures++; $display("FAIL arm_y170 obs=%b exp=%b", obs, 12'b0_0_0_0_11_000_0_0);
    end
    Kid_position_X = 10'd350; Kid_position_Y = 10'd169;
    tick();
    checks++;
    if (obs !== 12'b0_1_0_1_11_000_0_0) begin
      failures++; $display("FAIL warn_f1 obs=%b exp=%b", obs, 12'b0_1_0_1_11_000_0_0);
    end
    hitBullet = 1'b1;  // dropped in WARN
    tick();
    checks++;
    if (obs !== 12'b0_1_0_0_11_000_0_0) begin
      failures++; $display("FAIL warn_f2 obs=%b exp=%b", obs, 12'b0_1_0_0_11_000_0_0);
    end
    tick();
    checks++;
    if (obs !== 12'b0_1_0_1_11_000_0_0) begin
      failures++; $display("FAIL warn_f3 obs=%b exp=%b", obs, 12'b0_1_0_1_11_000_0_0);
    end
    tick();
    hitBullet = 1'b0;
    checks++;
    if (obs !== 12'b0_1_1_0_11_000_0_0) begin
      failures++; $display("FAIL active_entry obs=%b exp=%b", obs, 12'b0_1_1_0_11_000_0_0);
    end
  endtask

  task automatic test_kill();
    hitBullet = 1'b1;
    tick();
    checks++;
    if (obs !== 12'b0_1_1_1_10_000_0_0) begin
      failures++; $display("FAIL hit1 obs=%b exp=%b", obs, 12'b0_1_1_1_10_000_0_0);
    end
    repeat (8) tick();
    checks++;
    if (obs !== 12'b0_1_1_0_10_000_0_0) begin
      failures++; $display("FAIL invuln1 obs=%b exp=%b", obs, 12'b0_1_1_0_10_000_0_0);
    end
    tick();
    checks++;
    if (obs !== 12'b0_1_1_1_01_000_0_0) begin
      failures++; $display("FAIL hit2 obs=%b exp=%b", obs, 12'b0_1_1_1_01_000_0_0);
    end
    repeat (8) tick();
    checks++;
    if (obs !== 12'b0_1_1_0_01_000_0_0) begin
      failures++; $display("FAIL invuln2 obs=%b exp=%b", obs, 12'b0_1_1_0_01_000_0_0);
    end
    tick();
    hitBullet = 1'b0;
    checks++;
    if (obs !== 12'b1_0_0_0_00_001_0_0) begin
      failures++; $display("FAIL kill obs=%b exp=%b", obs, 12'b1_0_0_0_00_001_0_0);
    end
    tick();
    checks++;
    if (obs !== 12'b0_0_0_0_00_001_0_0) begin
      failures++; $display("FAIL reset_pulse_end obs=%b exp=%b", obs, 12'b0_0_0_0_00_001_0_0);
    end
    repeat (58) tick();
    checks++;
    if (obs !== 12'b0_0_0_0_00_001_0_0) begin
      failures++; $display("FAIL cooldown_last obs=%b exp=%b", obs, 12'b0_0_0_0_00_001_0_0);
    end
    tick();
    checks++;
    if (obs !== 12'b0_0_0_0_11_001_0_0) begin
      failures++; $display("FAIL cooldown_idle obs=%b exp=%b", obs, 12'b0_0_0_0_11_001_0_0);
    end
    tick();  // kid still in zone
    checks++;
    if (obs !== 12'b0_1_0_1_11_001_0_0) begin
      failures++; $display("FAIL rearm obs=%b exp=%b", obs, 12'b0_1_0_1_11_001_0_0);
    end
  endtask

  task automatic test_escape();
    repeat (3) tick();
    Enemy_position_X = 10'd3;
    tick();
    checks++;
    if (obs !== 12'b0_1_1_0_11_001_0_0) begin
      failures++; $display("FAIL no_escape_x3 obs=%b exp=%b", obs, 12'b0_1_1_0_11_001_0_0);
    end
    Enemy_position_X = 10'd2;
    tick();
    Enemy_position_X = 10'd300;
    checks++;
    if (obs !== 12'b1_0_0_0_11_001_0_0) begin
      failures++; $display("FAIL escape obs=%b exp=%b", obs, 12'b1_0_0_0_11_001_0_0);
    end
    Kid_position_X = 10'd0; Kid_position_Y = 10'd0;
    repeat (61) tick();
    checks++;
    if (obs !== 12'b0_0_0_0_11_001_0_0) begin
      failures++; $display("FAIL escape_idle obs=%b exp=%b", obs, 12'b0_0_0_0_11_001_0_0);
    end
    Kid_position_X = 10'd350; Kid_position_Y = 10'd169;
    arm_to_active();
  endtask

  task automatic test_clear();
    kill_wave();
    checks++;
    if (obs !== 12'b1_0_0_0_00_010_0_0) begin
      failures++; $display("FAIL kill2 obs=%b exp=%b", obs, 12'b1_0_0_0_00_010_0_0);
    end
    repeat (60) tick();
    checks++;
    if (obs !== 12'b0_0_0_0_11_010_0_0) begin
      failures++; $display("FAIL idle2 obs=%b exp=%b", obs, 12'b0_0_0_0_11_010_0_0);
    end
    arm_to_active();
    kill_wave();
    checks++;
    if (obs !== 12'b1_0_0_0_00_011_0_0) begin
      failures++; $display("FAIL kill3 obs=%b exp=%b", obs, 12'b1_0_0_0_00_011_0_0);
    end
    repeat (59) tick();
    checks++;
    if (obs !== 12'b0_0_0_0_00_011_0_0) begin
      failures++; $display("FAIL pre_clear obs=%b exp=%b", obs, 12'b0_0_0_0_00_011_0_0);
    end
    tick();
    checks++;
    if (obs !== 12'b0_0_0_0_00_011_0_1) begin
      failures++; $display("FAIL cleared obs=%b exp=%b", obs, 12'b0_0_0_0_00_011_0_1);
    end
    repeat (10) tick();
    checks++;
    if (obs !== 12'b0_0_0_0_00_011_0_1) begin
      failures++; $display("FAIL cleared_hold obs=%b exp=%b", obs, 12'b0_0_0_0_00_011_0_1);
    end
  endtask

  task automatic test_kid_dead();
    do_reset();
    arm_to_active();
    hitCat = 1'b1; hitBullet = 1'b1;
    tick();
    hitCat = 1'b0; hitBullet = 1'b0;
    checks++;
    if (obs !== 12'b0_1_0_0_11_000_1_0) begin
      failures++; $display("FAIL kid_dead obs=%b exp=%b", obs, 12'b0_1_0_0_11_000_1_0);
    end
    repeat (100) tick();
    checks++;
    if (obs !== 12'b0_1_0_0_11_000_1_0) begin
      failures++; $display("FAIL kid_dead_hold obs=%b exp=%b", obs, 12'b0_1_0_0_11_000_1_0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    arm_to_active();
    kill_wave();
    repeat (60) tick();
    arm_to_active();
    hitBullet = 1'b1;
    tick();
    hitBullet = 1'b0;
    tick();
    checks++;
    if (obs !== 12'b0_1_1_0_10_001_0_0) begin
      failures++; $display("FAIL wave2_hurt obs=%b exp=%b", obs, 12'b0_1_1_0_10_001_0_0);
    end
    #2 Reset_h = 1'b1;
    #1;
    checks++;
    if (obs !== 12'b1_0_0_0_11_000_0_0) begin
      failures++; $display("FAIL async_reset obs=%b exp=%b", obs, 12'b1_0_0_0_11_000_0_0);
    end
    @(negedge frame_clk);
    Reset_h = 1'b0;
  endtask

  initial begin
    Reset_h = 1'b1;
    Kid_position_X = 10'd0; Kid_position_Y = 10'd0;
    Enemy_position_X = 10'd300;
    hitBullet = 1'b0; hitCat = 1'b0;
    test_reset();
    test_arm();
    test_kill();
    test_escape();
    test_clear();
    test_kid_dead();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
